// File: rtl/slr_deser_ctrl_if.sv
// rtl/slr_deser_ctrl_if.sv - word handshake interface between deserializer and consumer
interface slr_deser_ctrl_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/slr_deser_ctrl.sv
// rtl/slr_deser_ctrl.sv - bit-period paced serial-to-parallel deserializer sequencer
module slr_deser_ctrl #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cont,
  input  logic              sin,
  input  logic              clr_ovr,
  output logic              busy,
  output logic              overrun,
  slr_deser_ctrl_if.master  word
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] div_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_nxt;
  logic             sample;
  logic             frame_end;

  // Next state plus sample/frame-end strobes; the shifted value is shared by the
  // shift register and the output word so the last bit lands in both at once.
  always_comb begin
    state_nxt = state;
    sample    = 1'b0;
    frame_end = 1'b0;
    sr_nxt    = {sin, sr[WIDTH-1:1]};
    case (state)
      IDLE: begin
        if (start) state_nxt = SHIFT;
      end
      SHIFT: begin
        sample    = (div_cnt == DIV_LAST);
        frame_end = sample && (bit_cnt == BIT_LAST);
        if (frame_end && !cont) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Bit-period divider, bit counter and shift register; counters sit at zero in
  // IDLE so frame entry always starts a fresh bit period.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      sr      <= '0;
    end else if (state == IDLE) begin
      div_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      div_cnt <= sample ? '0 : div_cnt + CNT_W'(1);
      if (sample) begin
        sr      <= sr_nxt;
        bit_cnt <= frame_end ? '0 : bit_cnt + BIT_W'(1);
      end
    end
  end

  // Output word handshake and sticky overrun; a drop at the same edge as
  // clr_ovr keeps overrun set because the set is evaluated last.
  always_ff @(posedge clk) begin
    if (rst) begin
      word.out_data  <= '0;
      word.out_valid <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      if (clr_ovr) overrun <= 1'b0;
      if (frame_end) begin
        if (!word.out_valid || word.out_ready) begin
          word.out_data  <= sr_nxt;
          word.out_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (word.out_valid && word.out_ready) begin
        word.out_valid <= 1'b0;
      end
    end
  end

  assign busy = (state == SHIFT);

endmodule

// File: tb/tb_slr_deser_ctrl.sv
// tb/tb_slr_deser_ctrl.sv - directed self-checking bench for slr_deser_ctrl
module tb_slr_deser_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic start = 1'b0, cont = 1'b0, sin = 1'b0, clr_ovr = 1'b0;
  logic busy, overrun;
  logic start1 = 1'b0, cont1 = 1'b0, sin1 = 1'b0, clr_ovr1 = 1'b0;
  logic busy1, overrun1;

  int passed = 0;
  int total  = 0;

  slr_deser_ctrl_if #(.WIDTH(8)) bus3 ();
  slr_deser_ctrl_if #(.WIDTH(8)) bus1 ();

  slr_deser_ctrl #(.WIDTH(8), .DIV(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .sin(sin),
    .clr_ovr(clr_ovr), .busy(busy), .overrun(overrun), .word(bus3)
  );

  slr_deser_ctrl #(.WIDTH(8), .DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .cont(cont1), .sin(sin1),
    .clr_ovr(clr_ovr1), .busy(busy1), .overrun(overrun1), .word(bus1)
  );

  always #5 clk = ~clk;

  // clock edge, then settle so registered outputs are read away from the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // one word on the DIV=3 instance: sin changes one cycle into each bit period,
  // sampled on the third edge; out_ready/clr_ovr are forced for the final edge
  task automatic send_word(input logic [7:0] w, input logic rdy_last, input logic clr_last);
    for (int i = 0; i < 8; i++) begin
      tick();
      start = 1'b0;
      sin   = w[i];
      tick();
      if (i == 7) begin
        bus3.out_ready = rdy_last;
        clr_ovr        = clr_last;
      end
      tick();
    end
  endtask

  initial begin
    logic [7:0] pat1;
    bus3.out_ready = 1'b0;
    bus1.out_ready = 1'b0;

    // reset state
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy3",  {31'd0, busy}, 32'd0);
    chk("rst_valid3", {31'd0, bus3.out_valid}, 32'd0);
    chk("rst_data3",  {24'd0, bus3.out_data}, 32'h00);
    chk("rst_ovr3",   {31'd0, overrun}, 32'd0);
    chk("rst_busy1",  {31'd0, busy1}, 32'd0);
    chk("rst_valid1", {31'd0, bus1.out_valid}, 32'd0);

    // 1: DIV=1, 0xA5 LSB first, word lands 8 edges after start
    pat1   = 8'hA5;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("t1_busy_e0", {31'd0, busy1}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      sin1 = pat1[i];
      if (i == 7) chk("t1_valid_e7", {31'd0, bus1.out_valid}, 32'd0);
      tick();
    end
    chk("t1_data",  {24'd0, bus1.out_data}, 32'hA5);
    chk("t1_valid", {31'd0, bus1.out_valid}, 32'd1);
    chk("t1_busy",  {31'd0, busy1}, 32'd0);
    bus1.out_ready = 1'b1;
    tick();
    bus1.out_ready = 1'b0;
    chk("t1_drain", {31'd0, bus1.out_valid}, 32'd0);

    // 2: DIV=3, sin held high, word at E0+24
    start = 1'b1;
    tick();
    start = 1'b0;
    sin   = 1'b1;
    for (int c = 1; c < 24; c++) tick();
    chk("t2_valid_e23", {31'd0, bus3.out_valid}, 32'd0);
    tick();
    chk("t2_data",  {24'd0, bus3.out_data}, 32'hFF);
    chk("t2_valid", {31'd0, bus3.out_valid}, 32'd1);
    chk("t2_busy",  {31'd0, busy}, 32'd0);
    bus3.out_ready = 1'b1;
    tick();
    chk("t2_drain", {31'd0, bus3.out_valid}, 32'd0);

    // 3: streaming 0x12 then 0x34, accept and reload at the same edge
    cont  = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    send_word(8'h12, 1'b1, 1'b0);
    chk("t3_data0",  {24'd0, bus3.out_data}, 32'h12);
    chk("t3_valid0", {31'd0, bus3.out_valid}, 32'd1);
    bus3.out_ready = 1'b0;
    send_word(8'h34, 1'b1, 1'b0);
    chk("t3_data1",  {24'd0, bus3.out_data}, 32'h34);
    chk("t3_valid1", {31'd0, bus3.out_valid}, 32'd1);
    chk("t3_ovr",    {31'd0, overrun}, 32'd0);
    chk("t3_busy",   {31'd0, busy}, 32'd1);

    // 4: consumer stalled, next word dropped; last frame of the stream
    bus3.out_ready = 1'b0;
    cont = 1'b0;
    send_word(8'h56, 1'b0, 1'b0);
    chk("t4_data", {24'd0, bus3.out_data}, 32'h34);
    chk("t4_ovr",  {31'd0, overrun}, 32'd1);
    chk("t4_busy", {31'd0, busy}, 32'd0);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    chk("t4_clr", {31'd0, overrun}, 32'd0);
    bus3.out_ready = 1'b1;
    tick();
    bus3.out_ready = 1'b0;
    chk("t4_drain", {31'd0, bus3.out_valid}, 32'd0);

    // 5: reset in the middle of bit 4
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      sin = 1'b1;
      tick();
      tick();
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_busy",  {31'd0, busy}, 32'd0);
    chk("t5_valid", {31'd0, bus3.out_valid}, 32'd0);
    chk("t5_data",  {24'd0, bus3.out_data}, 32'h00);
    start = 1'b1;
    tick();
    start = 1'b0;
    send_word(8'h3C, 1'b0, 1'b0);
    chk("t5_redo", {24'd0, bus3.out_data}, 32'h3C);
    bus3.out_ready = 1'b1;
    tick();
    bus3.out_ready = 1'b0;

    // 6: start held into the frame is ignored; drop and clr_ovr on one edge
    start = 1'b1;
    tick();
    send_word(8'h81, 1'b0, 1'b0);
    chk("t6_data",  {24'd0, bus3.out_data}, 32'h81);
    chk("t6_valid", {31'd0, bus3.out_valid}, 32'd1);
    chk("t6_busy",  {31'd0, busy}, 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    send_word(8'h7E, 1'b0, 1'b1);
    clr_ovr = 1'b0;
    chk("t6_ovr_win", {31'd0, overrun}, 32'd1);
    chk("t6_keep",    {24'd0, bus3.out_data}, 32'h81);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    chk("t6_clr", {31'd0, overrun}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
